// File: rtl/connect4_pkg.sv
// Shared Connect4 encodings: game FSM state, game status, column type and cursor home.
// Pure declarations; no logic, no latency.
package connect4_pkg;

    typedef enum logic [1:0] {
        GAME_INIT = 2'b00,
        P1_TURN   = 2'b01,
        P2_TURN   = 2'b10,
        END_GAME  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } game_status_t;

    typedef enum logic {
        MV_IDLE    = 1'b0,
        MV_PENDING = 1'b1
    } move_state_t;

    localparam int NUM_COLS_DEFAULT = 7;
    localparam int COL_W            = 3;

    typedef logic [COL_W-1:0] col_t;

    function automatic col_t home_col(input int num_cols);
        return col_t'(num_cols / 2);
    endfunction

    localparam col_t CURSOR_HOME = home_col(NUM_COLS_DEFAULT);

endpackage

// File: rtl/column_select_input_if.sv
// Move offer channel from the input front end to the game controller.
// Valid/ready: a move transfers on the clock edge where move_valid && move_ready.
interface column_select_input_if;
    import connect4_pkg::*;

    logic move_valid;
    logic move_ready;
    col_t move_col;
    logic move_player;

    modport master (output move_valid, output move_col, output move_player, input move_ready);
    modport slave  (input move_valid, input move_col, input move_player, output move_ready);

endinterface

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop sync -> stability counter -> one-cycle press pulse on debounced rise.
// Latency 2 + DEBOUNCE_CYCLES cycles from raw edge to pulse; no backpressure, pulses are never held.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta    <= 1'b0;
            sync    <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            meta    <= raw;
            sync    <= meta;
            level_q <= level;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/column_select_input.sv
// Connect4 player input: debounced buttons move the cursor and offer one move at a time.
// Press to cursor/move_valid/reject is 1 registered cycle; presses are dropped while a move waits for move_ready.
module column_select_input
    import connect4_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_COLS        = NUM_COLS_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  state_t                state,
    input  game_status_t          game_status,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_drop,
    input  logic [NUM_COLS-1:0]   col_full,
    column_select_input_if.master move,
    output col_t                  cursor,
    output logic                  reject
);

    localparam col_t HOME = home_col(NUM_COLS);
    localparam col_t LAST = col_t'(NUM_COLS - 1);

    logic        left_p;
    logic        right_p;
    logic        drop_p;
    logic        playing;
    move_state_t mstate;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clock (clock), .reset (reset), .raw (btn_left),  .press (left_p)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clock (clock), .reset (reset), .raw (btn_right), .press (right_p)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_drop (
        .clock (clock), .reset (reset), .raw (btn_drop),  .press (drop_p)
    );

    assign playing = (game_status == STILL_PLAYING) &&
                     ((state == P1_TURN) || (state == P2_TURN));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mstate           <= MV_IDLE;
            cursor           <= HOME;
            reject           <= 1'b0;
            move.move_valid  <= 1'b0;
            move.move_col    <= '0;
            move.move_player <= 1'b0;
        end else begin
            reject <= 1'b0;

            // Cursor sees the same pre-update idle state as the drop logic below.
            if (state == GAME_INIT) begin
                cursor <= HOME;
            end else if ((mstate == MV_IDLE) && playing && (left_p != right_p)) begin
                if (left_p) begin
                    cursor <= (cursor == '0) ? LAST : cursor - col_t'(1);
                end else begin
                    cursor <= (cursor == LAST) ? '0 : cursor + col_t'(1);
                end
            end

            case (mstate)
                MV_IDLE: begin
                    if (drop_p && playing) begin
                        if (col_full[cursor]) begin
                            reject <= 1'b1;
                        end else begin
                            mstate           <= MV_PENDING;
                            move.move_valid  <= 1'b1;
                            move.move_col    <= cursor;
                            move.move_player <= (state == P2_TURN);
                        end
                    end
                end
                MV_PENDING: begin
                    // Completed handshake and abort both retire the offer.
                    if (move.move_ready || !playing) begin
                        mstate          <= MV_IDLE;
                        move.move_valid <= 1'b0;
                    end
                end
                default: mstate <= MV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_select_input.sv
// Bench: hand sequences for reset/debounce/handshake timing, a directed table, then random actions vs a press-level model.
module tb_column_select_input;
    import connect4_pkg::*;

    localparam int DB = 4;
    localparam int NC = 7;

    logic         clock = 1'b0;
    logic         reset;
    state_t       state;
    game_status_t game_status;
    logic         btn_left, btn_right, btn_drop;
    logic [NC-1:0] col_full;
    col_t         cursor;
    logic         reject;

    column_select_input_if move();

    column_select_input #(.DEBOUNCE_CYCLES(DB), .NUM_COLS(NC)) dut (
        .clock       (clock),
        .reset       (reset),
        .state       (state),
        .game_status (game_status),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_drop    (btn_drop),
        .col_full    (col_full),
        .move        (move),
        .cursor      (cursor),
        .reject      (reject)
    );

    always #5 clock = ~clock;

    int n_vec    = 0;
    int n_err    = 0;
    int xfer_cnt = 0;
    int rej_cnt  = 0;

    // Count completed handshakes and reject pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (move.move_valid === 1'b1 && move.move_ready === 1'b1) xfer_cnt++;
        if (reject === 1'b1) rej_cnt++;
    end

    typedef struct {
        logic [2:0]   btn;   // {left, right, drop}
        state_t       st;
        game_status_t gs;
        logic [6:0]   full;
        logic         rdy;
        int           cur;
        logic         vld;
        int           col;
        logic         ply;
        int           rej;
        int           xfer;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete button action: settle settings, hold buttons, release, wait for quiet.
    task automatic act(input logic [2:0] btn, input state_t st, input game_status_t gs,
                       input logic [6:0] full, input logic rdy,
                       output int rej_d, output int xfer_d);
        int r0, x0;
        @(posedge clock); #1;
        state = st; game_status = gs; col_full = full; move.move_ready = rdy;
        r0 = rej_cnt; x0 = xfer_cnt;
        repeat (2) @(posedge clock);
        #1 {btn_left, btn_right, btn_drop} = btn;
        repeat (8) @(posedge clock);
        #1 {btn_left, btn_right, btn_drop} = 3'b000;
        repeat (10) @(posedge clock);
        @(negedge clock); #1;
        rej_d  = rej_cnt - r0;
        xfer_d = xfer_cnt - x0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        int rd, xd, x_before;
        int m_cur, m_col, e_rej, e_x;
        logic m_pend, m_ply, idle_play, playing;
        logic [2:0] btn;
        state_t st;
        game_status_t gs;
        logic [6:0] full;
        logic rdy;
        int r;

        reset = 1'b1; state = GAME_INIT; game_status = STILL_PLAYING;
        btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0;
        col_full = '0; move.move_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_cursor", cursor, 3);
        chk("rst_valid", move.move_valid, 0);
        chk("rst_col", move.move_col, 0);
        chk("rst_player", move.move_player, 0);
        chk("rst_reject", reject, 0);
        @(posedge clock); #1 reset = 1'b0;

        // Debounce: 3-cycle glitch is filtered, a held press lands exactly 7 cycles after the edge
        state = P1_TURN;
        repeat (2) @(posedge clock);
        #1 btn_right = 1'b1;
        repeat (3) @(posedge clock);
        #1 btn_right = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("glitch_cursor", cursor, 3);
        @(posedge clock); #1 btn_right = 1'b1;
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("deb_cycle6", cursor, 3);
        @(negedge clock);
        chk("deb_cycle7", cursor, 4);
        @(posedge clock); #1 btn_right = 1'b0;
        repeat (10) @(posedge clock);

        // Handshake timing: valid holds until the ready edge, then falls
        act(3'b001, P1_TURN, STILL_PLAYING, 7'd0, 1'b0, rd, xd);
        chk("hs_valid", move.move_valid, 1);
        chk("hs_col", move.move_col, 4);
        chk("hs_player", move.move_player, 0);
        @(posedge clock); #1 move.move_ready = 1'b1;
        @(negedge clock);
        chk("hs_valid_at_ready", move.move_valid, 1);
        @(negedge clock);
        chk("hs_valid_after", move.move_valid, 0);
        #1 move.move_ready = 1'b0;

        // Asynchronous reset while PENDING
        act(3'b001, P1_TURN, STILL_PLAYING, 7'd0, 1'b0, rd, xd);
        chk("pre_rst_valid", move.move_valid, 1);
        x_before = xfer_cnt;
        @(negedge clock); #2 reset = 1'b1;
        #1;
        chk("arst_valid", move.move_valid, 0);
        chk("arst_cursor", cursor, 3);
        chk("arst_col", move.move_col, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("post_rst_cursor", cursor, 3);
        chk("post_rst_valid", move.move_valid, 0);
        chk("post_rst_xfer", xfer_cnt, x_before);

        // Directed table from cursor 3, idle
        tbl[0]  = '{3'b010, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 4, 1'b0, 0, 1'b0, 0, 0};
        tbl[1]  = '{3'b010, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 5, 1'b0, 0, 1'b0, 0, 0};
        tbl[2]  = '{3'b010, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 6, 1'b0, 0, 1'b0, 0, 0};
        tbl[3]  = '{3'b010, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 0, 1'b0, 0, 1'b0, 0, 0};
        tbl[4]  = '{3'b100, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 6, 1'b0, 0, 1'b0, 0, 0};
        tbl[5]  = '{3'b110, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 6, 1'b0, 0, 1'b0, 0, 0};
        tbl[6]  = '{3'b100, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 5, 1'b0, 0, 1'b0, 0, 0};
        tbl[7]  = '{3'b100, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 4, 1'b0, 0, 1'b0, 0, 0};
        tbl[8]  = '{3'b100, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 3, 1'b0, 0, 1'b0, 0, 0};
        tbl[9]  = '{3'b100, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 2, 1'b0, 0, 1'b0, 0, 0};
        tbl[10] = '{3'b001, P2_TURN,  STILL_PLAYING, 7'b0000100, 1'b0, 2, 1'b0, 0, 1'b0, 1, 0};
        tbl[11] = '{3'b001, P2_TURN,  STILL_PLAYING, 7'd0,       1'b0, 2, 1'b1, 2, 1'b1, 0, 0};
        tbl[12] = '{3'b010, P2_TURN,  STILL_PLAYING, 7'd0,       1'b0, 2, 1'b1, 2, 1'b1, 0, 0};
        tbl[13] = '{3'b000, P2_TURN,  STILL_PLAYING, 7'd0,       1'b1, 2, 1'b0, 0, 1'b0, 0, 1};
        tbl[14] = '{3'b011, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 3, 1'b1, 2, 1'b0, 0, 0};
        tbl[15] = '{3'b000, P1_TURN,  P1_WINS,       7'd0,       1'b0, 3, 1'b0, 0, 1'b0, 0, 0};
        tbl[16] = '{3'b001, END_GAME, STILL_PLAYING, 7'd0,       1'b0, 3, 1'b0, 0, 1'b0, 0, 0};
        tbl[17] = '{3'b010, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 4, 1'b0, 0, 1'b0, 0, 0};
        tbl[18] = '{3'b010, P1_TURN,  STILL_PLAYING, 7'd0,       1'b0, 5, 1'b0, 0, 1'b0, 0, 0};
        tbl[19] = '{3'b000, GAME_INIT, STILL_PLAYING, 7'd0,      1'b0, 3, 1'b0, 0, 1'b0, 0, 0};

        for (int i = 0; i < 20; i++) begin
            act(tbl[i].btn, tbl[i].st, tbl[i].gs, tbl[i].full, tbl[i].rdy, rd, xd);
            chk($sformatf("tbl%0d_cursor", i), cursor, tbl[i].cur);
            chk($sformatf("tbl%0d_valid", i), move.move_valid, tbl[i].vld);
            chk($sformatf("tbl%0d_reject", i), rd, tbl[i].rej);
            chk($sformatf("tbl%0d_xfer", i), xd, tbl[i].xfer);
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d_col", i), move.move_col, tbl[i].col);
                chk($sformatf("tbl%0d_player", i), move.move_player, tbl[i].ply);
            end
        end

        // Random actions against a press-level model
        move.move_ready = 1'b0;
        do_reset();
        m_cur = 3; m_pend = 1'b0; m_col = 0; m_ply = 1'b0;
        for (int n = 0; n < 60; n++) begin
            btn = 3'($urandom_range(1, 7));
            r = $urandom_range(0, 9);
            st = (r == 0) ? GAME_INIT : (r == 1) ? END_GAME : (r < 6) ? P1_TURN : P2_TURN;
            gs = ($urandom_range(0, 5) == 0) ? game_status_t'(2'($urandom_range(1, 3))) : STILL_PLAYING;
            full = 7'($urandom) & 7'($urandom);
            rdy = 1'($urandom_range(0, 1));

            playing = (gs == STILL_PLAYING) && (st == P1_TURN || st == P2_TURN);
            e_rej = 0; e_x = 0;
            if (m_pend) begin
                if (rdy) e_x++;
                if (rdy || !playing) m_pend = 1'b0;
            end
            idle_play = !m_pend && playing;
            if (st == GAME_INIT) begin
                m_cur = 3;
            end else if (idle_play) begin
                if (btn[0]) begin
                    if (full[m_cur]) e_rej = 1;
                    else begin
                        m_pend = 1'b1; m_col = m_cur; m_ply = (st == P2_TURN);
                    end
                end
                if (btn[2] && !btn[1]) m_cur = (m_cur + NC - 1) % NC;
                else if (btn[1] && !btn[2]) m_cur = (m_cur + 1) % NC;
                if (m_pend && rdy) begin
                    e_x++;
                    m_pend = 1'b0;
                end
            end

            act(btn, st, gs, full, rdy, rd, xd);
            chk($sformatf("rnd%0d_cursor", n), cursor, m_cur);
            chk($sformatf("rnd%0d_valid", n), move.move_valid, m_pend);
            chk($sformatf("rnd%0d_reject", n), rd, e_rej);
            chk($sformatf("rnd%0d_xfer", n), xd, e_x);
            if (m_pend) begin
                chk($sformatf("rnd%0d_col", n), move.move_col, m_col);
                chk($sformatf("rnd%0d_player", n), move.move_player, m_ply);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
